quantser_array: RTL
===================

Name: quantser_array

Overview:
- Multi-lane successor to the single-lane quantizer-serializer.
- Captures N parallel BDIN-bit accumulator words and selects a runtime-configured bit window from each.
- Optionally rounds and saturates each selected value, in signed or unsigned mode.
- Serializes all lanes in lock-step, MSB first, one bit per lane per cycle, with a busy/valid/last handshake to the downstream bit-serial consumer.

Parameters:
N, 8, number of lanes.
BDIN, 32, input word width per lane.
BDOUTMAX, 16, maximum output precision in bits; must satisfy BDOUTMAX <= BDIN.
MAXBDIP, $clog2(BDIN), derived; width of msbidx.
MAXBDOP, $clog2(BDOUTMAX), derived; width of bdout.

Ports:
clk  in  1  clock, rising edge.
clr  in  1  reset, asynchronous, active-high.
msbidx  in  MAXBDIP  bit position of the window MSB in din.
bdout  in  MAXBDOP  output bit depth minus 1; 0 means 1 bit.
signed_en  in  1  1 = two's-complement input and output; 0 = unsigned.
round_en  in  1  1 = round half up using the bit just below the window.
sat_en  in  1  1 = saturate on overflow; 0 = wrap (truncate).
start  in  1  request a new conversion; honoured only while busy=0.
din  in  N*BDIN  lane i occupies din[i*BDIN +: BDIN].
busy  out  1  high from acceptance through the final bit cycle.
valid  out  1  dout carries a valid bit this cycle.
last  out  1  high with the final (LSB) bit of a stream.
dout  out  N  lane i serialized bit.

Behaviour:
- Reset: clr high asynchronously forces busy=0, valid=0, last=0 and dout=0, clears all internal state and aborts any stream in progress. Outputs stay 0 while clr is high.
- Accept: start=1 with busy=0 at edge E0. din, msbidx, bdout and the three mode bits are registered. busy=1 after E0. start=1 while busy=1 is ignored; there is no queueing.
- Quantize stage: at E1, per-lane quantized words (bdout+1 bits) load into the shift registers. Inputs may change freely after E0.
- Serialize: valid=1 from E1 for exactly bdout+1 cycles. Cycle k (k=0..bdout) presents bit bdout-k of every lane on dout. last=1 in cycle k=bdout.
- After the edge that retires the last bit, busy, valid, last and dout all return to 0.
- A new start is accepted at the earliest edge where busy=0, so there is a minimum 1-cycle gap between streams.
- States: IDLE -> (start) LOAD -> SHIFT (count bdout down to 0) -> IDLE. clr returns to IDLE from any state.
- Window: LSB index L = msbidx - bdout.
  - If L < 0, bits below 0 are zero-padded.
  - w = din[msbidx:L], which is bdout+1 bits.
- Rounding: when round_en=1 and L >= 1, add din[L-1] to w, computed 1 bit wider. Negative ties round toward +infinity. No effect when L <= 0.
- Overflow, signed mode: din[BDIN-1:msbidx] not all equal, or the rounded value exceeds the signed (bdout+1)-bit range.
- Overflow, unsigned mode: din[BDIN-1:msbidx+1] not all zero, or the rounding carry leaves bit bdout+1.
- Saturation (sat_en=1, overflow):
  - Signed: 0111..1 if din[BDIN-1]=0, else 1000..0.
  - Unsigned: all ones.
- sat_en=0: low bdout+1 bits of the rounded w (wrap).
- All lanes share config and timing; lanes are independent only in data.

Test Plan:
1. Unsigned, msbidx=7, bdout=3, round off, lane0 din=0xB4 -> after E1, valid for 4 cycles, dout[0]=1,0,1,1; last only on the 4th cycle; busy drops the cycle after. Same config with round on, lane1 din=0xB8 -> 1,1,0,0.
2. Signed, sat on, msbidx=7, bdout=3: din=0x170 -> 0111; din=0xFFFFFE80 -> 1000. Repeat with sat off -> 0111 and 1000 (wrapped window).
3. Signed, sat on, round on, msbidx=7, bdout=3, din=0x78 -> rounding carry overflows -> 0111. Same with sat off -> 1000.
4. bdout=0, msbidx=31, din=1<<31, unsigned -> single cycle with valid=1, last=1, dout=1. Next start is accepted 1 cycle after busy falls.
5. Mid-stream events:
   - start held high during a stream -> ignored; bit sequence unchanged.
   - clr pulse asynchronously between edges during bit 2 -> all outputs 0 immediately.
   - Fresh start after clr deasserts -> correct full stream.
6. Zero-padding: msbidx=1, bdout=3, din=0x3, round on -> 1,1,0,0 (padding; rounding has no effect), identical on all N lanes.

Source files
------------

// File: rtl/quantser_array.sv
// N-lane quantizer/serializer: captures N accumulator words, extracts a configurable bit window
// per lane (optional round/saturate), then shifts all lanes out MSB first in lock-step.
module quantser_array #(
  parameter int N        = 8,
  parameter int BDIN     = 32,
  parameter int BDOUTMAX = 16,
  parameter int MAXBDIP  = $clog2(BDIN),
  parameter int MAXBDOP  = $clog2(BDOUTMAX)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [MAXBDIP-1:0]   msbidx,
  input  logic [MAXBDOP-1:0]   bdout,
  input  logic                 signed_en,
  input  logic                 round_en,
  input  logic                 sat_en,
  input  logic                 start,
  input  logic [N*BDIN-1:0]    din,
  output logic                 busy,
  output logic                 valid,
  output logic                 last,
  output logic [N-1:0]         dout
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;

  // Extended word: din above BDOUTMAX+1 zero bits so negative window LSBs pad with zeros
  // and the round bit always lands at bit 0 of the shifted word.
  localparam int EW = BDIN + BDOUTMAX + 1;
  localparam int SW = $clog2(EW);
  localparam logic [MAXBDOP-1:0] TopIdx = MAXBDOP'(BDOUTMAX - 1);

  logic [1:0]                      state_q;
  logic [N*BDIN-1:0]               din_q;
  logic [MAXBDIP-1:0]              msbidx_q;
  logic [MAXBDOP-1:0]              bdout_q;
  logic                            signed_q;
  logic                            round_q;
  logic                            sat_q;
  logic [MAXBDOP-1:0]              cnt_q;
  logic [N-1:0][BDOUTMAX-1:0]      sh_q;

  logic [SW-1:0]                   sh_amt;
  logic [BDOUTMAX-1:0]             mask;
  logic [BDIN-1:0]                 hi_mask;
  logic [BDOUTMAX-1:0]             q_word [N];

  assign sh_amt  = SW'(msbidx_q) + SW'(BDOUTMAX) - SW'(bdout_q);
  assign mask    = {BDOUTMAX{1'b1}} >> (TopIdx - bdout_q);
  assign hi_mask = {BDIN{1'b1}} << msbidx_q;

  always_comb begin
    logic [BDIN-1:0]     lane;
    logic [EW-1:0]       shifted;
    logic [BDOUTMAX-1:0] w;
    logic                rbit;
    logic [BDOUTMAX:0]   rounded;
    logic [BDIN-1:0]     hi_sel;
    logic                ovf;
    logic [BDOUTMAX-1:0] satv;
    lane    = '0;
    shifted = '0;
    w       = '0;
    rbit    = 1'b0;
    rounded = '0;
    hi_sel  = '0;
    ovf     = 1'b0;
    satv    = '0;
    for (int i = 0; i < N; i++) begin
      lane    = din_q[i*BDIN +: BDIN];
      shifted = {lane, {(BDOUTMAX + 1){1'b0}}} >> sh_amt;
      w       = shifted[BDOUTMAX:1] & mask;
      rbit    = round_q & shifted[0];
      rounded = {1'b0, w} + (BDOUTMAX + 1)'(rbit);
      hi_sel  = lane & hi_mask;
      if (signed_q) begin
        ovf  = !((hi_sel == '0) || (hi_sel == hi_mask)) || ((w == (mask >> 1)) && rbit);
        satv = lane[BDIN-1] ? (~(mask >> 1) & mask) : (mask >> 1);
      end else begin
        ovf  = ((lane & (hi_mask << 1)) != '0) || ((w == mask) && rbit);
        satv = mask;
      end
      q_word[i] = (sat_q && ovf) ? satv : (rounded[BDOUTMAX-1:0] & mask);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= StIdle;
      din_q    <= '0;
      msbidx_q <= '0;
      bdout_q  <= '0;
      signed_q <= 1'b0;
      round_q  <= 1'b0;
      sat_q    <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            din_q    <= din;
            msbidx_q <= msbidx;
            bdout_q  <= bdout;
            signed_q <= signed_en;
            round_q  <= round_en;
            sat_q    <= sat_en;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          // Left-align so every lane's current bit is always at the shift register MSB.
          for (int i = 0; i < N; i++) begin
            sh_q[i] <= q_word[i] << (TopIdx - bdout_q);
          end
          cnt_q   <= bdout_q;
          state_q <= StShift;
        end
        StShift: begin
          if (cnt_q == '0) begin
            sh_q    <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            for (int i = 0; i < N; i++) begin
              sh_q[i] <= sh_q[i] << 1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy  = (state_q != StIdle);
    valid = (state_q == StShift);
    last  = valid && (cnt_q == '0);
    dout  = '0;
    for (int i = 0; i < N; i++) begin
      dout[i] = valid & sh_q[i][BDOUTMAX-1];
    end
  end

endmodule
